// File: rtl/controlador_semaforos_pkg.sv
// Shared definitions for the two-way crossing sequencer:
// light codes, FSM state codes and the phase timing defaults.
package controlador_semaforos_pkg;

    localparam logic [1:0] VERDE    = 2'b10;
    localparam logic [1:0] AMARILLO = 2'b01;
    localparam logic [1:0] ROJO     = 2'b00;

    localparam int T_VERDE_A_DEF   = 4;
    localparam int T_AMARILLO_DEF  = 2;
    localparam int T_TODO_ROJO_DEF = 1;
    localparam int T_VERDE_B_DEF   = 3;
    localparam int CNT_W_DEF       = 8;

    typedef enum logic [2:0] {
        A_VERDE = 3'd0,
        A_AMAR  = 3'd1,
        ROJO_AB = 3'd2,
        B_VERDE = 3'd3,
        B_AMAR  = 3'd4,
        ROJO_BA = 3'd5
    } estado_t;

    typedef struct packed {
        logic [1:0] luz_a;
        logic [1:0] luz_b;
    } luces_t;

    function automatic luces_t decodificar(input estado_t s);
        luces_t l;
        l.luz_a = ROJO;
        l.luz_b = ROJO;
        case (s)
            A_VERDE: l.luz_a = VERDE;
            A_AMAR:  l.luz_a = AMARILLO;
            B_VERDE: l.luz_b = VERDE;
            B_AMAR:  l.luz_b = AMARILLO;
            default: begin
                l.luz_a = ROJO;
                l.luz_b = ROJO;
            end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/controlador_semaforos_temporizador.sv
// Phase counter: clr zeroes it regardless of enb,
// otherwise counts while enb and saturates at all-ones.
module temporizador_fase
    import controlador_semaforos_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enb,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (enb && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/controlador_semaforos.sv
// Two-way crossing sequencer: A green by default, a latched
// request runs one A->B->A cycle with yellow and all-red phases.
module controlador_semaforos
    import controlador_semaforos_pkg::*;
#(
    parameter int T_VERDE_A   = T_VERDE_A_DEF,
    parameter int T_AMARILLO  = T_AMARILLO_DEF,
    parameter int T_TODO_ROJO = T_TODO_ROJO_DEF,
    parameter int T_VERDE_B   = T_VERDE_B_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enb,
    input  logic       sensor_B,
    input  logic       boton_A,
    output logic [1:0] semaforo_A,
    output logic [1:0] semaforo_B,
    output logic [2:0] estado
);

    localparam logic [CNT_W-1:0] LIM_VA = CNT_W'(T_VERDE_A - 1);
    localparam logic [CNT_W-1:0] LIM_AM = CNT_W'(T_AMARILLO - 1);
    localparam logic [CNT_W-1:0] LIM_TR = CNT_W'(T_TODO_ROJO - 1);
    localparam logic [CNT_W-1:0] LIM_VB = CNT_W'(T_VERDE_B - 1);

    estado_t          state;
    estado_t          nxt;
    logic             pend;
    logic             req;
    logic             salir;
    logic             min_ok;
    logic             cnt_enb;
    logic             clr;
    logic [CNT_W-1:0] cnt;
    luces_t           luces;

    assign req    = sensor_B | boton_A;
    assign min_ok = (cnt >= LIM_VA);

    always_comb begin
        salir = 1'b0;
        nxt   = state;
        case (state)
            A_VERDE: begin
                salir = min_ok && (pend || req);
                nxt   = A_AMAR;
            end
            A_AMAR: begin
                salir = (cnt == LIM_AM);
                nxt   = ROJO_AB;
            end
            ROJO_AB: begin
                salir = (cnt == LIM_TR);
                nxt   = B_VERDE;
            end
            B_VERDE: begin
                salir = (cnt == LIM_VB);
                nxt   = B_AMAR;
            end
            B_AMAR: begin
                salir = (cnt == LIM_AM);
                nxt   = ROJO_BA;
            end
            ROJO_BA: begin
                salir = (cnt == LIM_TR);
                nxt   = A_VERDE;
            end
            default: begin
                salir = 1'b1;
                nxt   = A_VERDE;
            end
        endcase
        if (!salir) begin
            nxt = state;
        end
    end

    // A-green holds its count once the minimum green is reached
    assign cnt_enb = enb && !(state == A_VERDE && min_ok);
    assign clr     = enb && salir;

    temporizador_fase #(
        .CNT_W (CNT_W)
    ) u_temporizador (
        .clk   (clk),
        .reset (reset),
        .enb   (cnt_enb),
        .clr   (clr),
        .cnt   (cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= A_VERDE;
        end else if (enb) begin
            state <= nxt;
        end
    end

    // Clearing on entry to B green beats a same-cycle request
    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= 1'b0;
        end else if (enb) begin
            if (state == ROJO_AB && salir) begin
                pend <= 1'b0;
            end else if (state != B_VERDE && req) begin
                pend <= 1'b1;
            end
        end
    end

    assign luces      = decodificar(state);
    assign semaforo_A = luces.luz_a;
    assign semaforo_B = luces.luz_b;
    assign estado     = state;

endmodule

// File: tb/tb_controlador_semaforos.sv
// Scenario bench for the crossing sequencer: a cycle model feeds a
// scoreboard queue, and each scenario also checks fixed timelines.
module tb_controlador_semaforos;

    logic       clk;
    logic       reset;
    logic       enb;
    logic       sensor_B;
    logic       boton_A;
    logic [1:0] semaforo_A;
    logic [1:0] semaforo_B;
    logic [2:0] estado;

    int n_cmp;
    int n_bad;

    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] e;
    } obs_t;

    obs_t sb[$];

    // reference model state
    int  m_ph;
    int  m_cnt;
    bit  m_pend;

    logic [1:0] oa;
    logic [1:0] ob;
    logic [2:0] oe;

    controlador_semaforos dut (
        .clk        (clk),
        .reset      (reset),
        .enb        (enb),
        .sensor_B   (sensor_B),
        .boton_A    (boton_A),
        .semaforo_A (semaforo_A),
        .semaforo_B (semaforo_B),
        .estado     (estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ph_len(input int ph);
        case (ph)
            0: return 4;
            1, 4: return 2;
            2, 5: return 1;
            default: return 3;
        endcase
    endfunction

    function automatic obs_t ph_obs(input int ph);
        obs_t o;
        o.e = 3'(ph);
        o.a = 2'b00;
        o.b = 2'b00;
        if (ph == 0) o.a = 2'b10;
        if (ph == 1) o.a = 2'b01;
        if (ph == 3) o.b = 2'b10;
        if (ph == 4) o.b = 2'b01;
        return o;
    endfunction

    task automatic model_edge(input logic r, input logic en,
                              input logic s, input logic bt);
        bit leave;
        if (r) begin
            m_ph = 0;
            m_cnt = 0;
            m_pend = 0;
        end else if (en) begin
            if (m_ph == 0)
                leave = (m_cnt >= ph_len(0) - 1) && (m_pend || s || bt);
            else
                leave = (m_cnt == ph_len(m_ph) - 1);
            if (m_ph == 2 && leave) m_pend = 0;
            else if (m_ph != 3 && (s || bt)) m_pend = 1;
            if (leave) begin
                m_ph = (m_ph + 1) % 6;
                m_cnt = 0;
            end else if (!(m_ph == 0 && m_cnt >= ph_len(0) - 1)) begin
                m_cnt++;
            end
        end
    endtask

    // one clock: drive, check current outputs, advance model, cross edge
    task automatic step(input logic r, input logic en,
                        input logic s, input logic bt);
        obs_t exp_o;
        obs_t got;
        reset = r;
        enb = en;
        sensor_B = s;
        boton_A = bt;
        #1;
        got = {semaforo_A, semaforo_B, estado};
        oa = semaforo_A;
        ob = semaforo_B;
        oe = estado;
        if (sb.size() > 0) begin
            exp_o = sb.pop_front();
            n_cmp++;
            if (got !== exp_o) begin
                n_bad++;
                $display("FAIL scoreboard t=%0t got A=%b B=%b e=%0d exp A=%b B=%b e=%0d",
                         $time, got.a, got.b, got.e, exp_o.a, exp_o.b, exp_o.e);
            end
        end
        n_cmp++;
        if (semaforo_A === 2'b11 || semaforo_B === 2'b11 ||
            (semaforo_A !== 2'b00 && semaforo_B !== 2'b00)) begin
            n_bad++;
            $display("FAIL safety t=%0t A=%b B=%b need one red and no 11",
                     $time, semaforo_A, semaforo_B);
        end
        model_edge(r, en, s, bt);
        sb.push_back(ph_obs(m_ph));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (oa !== 2'b10 || ob !== 2'b00 || oe !== 3'd0) begin
                n_bad++;
                $display("FAIL reset_idle c=%0d got A=%b B=%b e=%0d need A=10 B=00 e=0",
                         c, oa, ob, oe);
            end
        end
    endtask

    task automatic test_sensor_pulse();
        logic [1:0] ea;
        logic [1:0] eb;
        do_reset();
        for (int c = 0; c < 26; c++) begin
            step(1'b0, 1'b1, c == 0, 1'b0);
            ea = 2'b00;
            eb = 2'b00;
            if (c <= 3 || c >= 13) ea = 2'b10;
            else if (c <= 5) ea = 2'b01;
            if (c >= 7 && c <= 9) eb = 2'b10;
            else if (c >= 10 && c <= 11) eb = 2'b01;
            n_cmp++;
            if (oa !== ea || ob !== eb) begin
                n_bad++;
                $display("FAIL sensor_pulse c=%0d got A=%b B=%b need A=%b B=%b",
                         c, oa, ob, ea, eb);
            end
        end
    endtask

    task automatic test_boton();
        do_reset();
        for (int c = 0; c < 14; c++) begin
            step(1'b0, 1'b1, 1'b0, c == 10);
            if (c == 10 || c == 11) begin
                n_cmp++;
                if (oa !== ((c == 11) ? 2'b01 : 2'b10)) begin
                    n_bad++;
                    $display("FAIL boton c=%0d got A=%b need %b",
                             c, oa, (c == 11) ? 2'b01 : 2'b10);
                end
            end
        end
    endtask

    task automatic test_freeze();
        int nb;
        nb = 0;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            step(1'b0, !(c >= 8 && c <= 12), c == 0, 1'b0);
            if (ob === 2'b10) nb++;
            if (c >= 8 && c <= 13) begin
                n_cmp++;
                if (oa !== 2'b00 || ob !== 2'b10 || oe !== 3'd3) begin
                    n_bad++;
                    $display("FAIL freeze c=%0d got A=%b B=%b e=%0d need A=00 B=10 e=3",
                             c, oa, ob, oe);
                end
            end
        end
        n_cmp++;
        if (nb !== 8) begin
            n_bad++;
            $display("FAIL freeze_len got %0d B-green cycles need 8", nb);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c <= 10; c++) step(c == 10, 1'b1, c == 0, 1'b0);
        for (int c = 11; c < 26; c++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (oa !== 2'b10 || ob !== 2'b00) begin
                n_bad++;
                $display("FAIL reset_mid c=%0d got A=%b B=%b need A=10 B=00",
                         c, oa, ob);
            end
        end
        // reset while frozen still returns to A green
        for (int c = 0; c < 9; c++) step(1'b0, 1'b1, c == 0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (oe !== 3'd0 || oa !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_over_enb got e=%0d A=%b need e=0 A=10", oe, oa);
        end
    endtask

    task automatic test_ignored_in_b_verde();
        do_reset();
        for (int c = 0; c < 30; c++) begin
            step(1'b0, 1'b1, c == 0 || c == 8, 1'b0);
            if (c >= 13) begin
                n_cmp++;
                if (oa !== 2'b10) begin
                    n_bad++;
                    $display("FAIL ignored_b_verde c=%0d got A=%b need 10", c, oa);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] ea;
        do_reset();
        for (int c = 0; c < 36; c++) begin
            step(1'b0, 1'b1, c == 0 || c == 10, 1'b0);
            ea = 2'b00;
            if ((c >= 13 && c <= 16) || c >= 26) ea = 2'b10;
            else if (c == 17 || c == 18) ea = 2'b01;
            if (c >= 13) begin
                n_cmp++;
                if (oa !== ea) begin
                    n_bad++;
                    $display("FAIL back_to_back c=%0d got A=%b need %b", c, oa, ea);
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_ph = 0;
        m_cnt = 0;
        m_pend = 0;
        reset = 1'b1;
        enb = 1'b1;
        sensor_B = 1'b0;
        boton_A = 1'b0;
        @(negedge clk);
        test_reset();
        test_sensor_pulse();
        test_boton();
        test_freeze();
        test_reset_mid();
        test_ignored_in_b_verde();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
